// File: rtl/mipsguc_pkg.sv
// Shared register-file types for the WB arbiter, decoder and register file.
package mipsguc_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     data_t;

  typedef struct packed {
    logic      vld;
    reg_addr_t addr;
    data_t     dat;
  } wb_req_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Tracks MDU-pending destination registers and the in-flight MDU result count.
// Latency: busy/count update at the clock edge; hazard_stall and mdu_issue_ok are combinational.
// Backpressure: mdu_issue_ok drops at MAX_OUTSTANDING; a drain in the same cycle returns its credit.
module regfile_scoreboard
  import mipsguc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      issue_vld,
  input  reg_addr_t issue_reg,
  input  logic      clr_vld,
  input  reg_addr_t clr_reg,
  input  reg_addr_t id_rs,
  input  reg_addr_t id_rt,
  input  reg_addr_t id_dest,
  input  logic      id_dest_valid,
  output logic      hazard_stall,
  output logic      mdu_issue_ok
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  logic [(1 << REG_ADDR_W)-1:0] busy;
  logic [CNT_W-1:0]             outstanding;
  logic                         credit_ret;
  logic                         room;
  logic                         set_vld;
  logic                         dec_vld;

  // A drain of a still-pending register frees a slot this very cycle.
  assign credit_ret = clr_vld && busy[clr_reg];
  assign room       = (outstanding < CNT_MAX) || credit_ret;
  assign set_vld    = issue_vld && (issue_reg != REG_ZERO) && room;
  assign dec_vld    = credit_ret && (outstanding != '0);

  assign mdu_issue_ok = !reset && room;
  assign hazard_stall = !reset && (
      (busy[id_rs] && (id_rs != REG_ZERO)) ||
      (busy[id_rt] && (id_rt != REG_ZERO)) ||
      (id_dest_valid && busy[id_dest] && (id_dest != REG_ZERO)));

  always_ff @(posedge clk) begin
    if (reset) begin
      busy        <= '0;
      outstanding <= '0;
    end else begin
      if (clr_vld) busy[clr_reg] <= 1'b0;
      if (set_vld) busy[issue_reg] <= 1'b1;
      case ({set_vld, dec_vld})
        2'b10:   if (outstanding != CNT_MAX) outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between pipeline WB and the MDU via a 1-entry hold.
// Latency: pipe write 0 cycles; MDU accept->RegWrite >= 1 cycle.
// Backpressure: mdu_ready low while hold is full; starve_stall asks for bubbles after STARVE_LIMIT.
module regfile_wb_arbiter
  import mipsguc_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipe_wb_en,
  input  logic [REG_ADDR_W-1:0] pipe_wb_reg,
  input  logic [DATA_W-1:0]     pipe_wb_data,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [REG_ADDR_W-1:0] mdu_reg,
  input  logic [DATA_W-1:0]     mdu_data,
  input  logic                  mdu_issue,
  input  logic [REG_ADDR_W-1:0] mdu_issue_reg,
  output logic                  mdu_issue_ok,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_dest_valid,
  output logic                  hazard_stall,
  output logic                  starve_stall,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0]     write_data
);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STARVE_LIMIT);

  wb_req_t         hold;
  wb_req_t         wr;
  logic            pipe_eff;
  logic            drain;
  logic [SC_W-1:0] starve_cnt;

  assign pipe_eff = pipe_wb_en && (pipe_wb_reg != REG_ZERO);
  assign drain    = !reset && !pipe_eff && hold.vld;

  always_comb begin
    wr = '0;
    if (!reset) begin
      if (pipe_eff)      wr = '{vld: 1'b1, addr: pipe_wb_reg, dat: pipe_wb_data};
      else if (hold.vld) wr = hold;
    end
  end

  assign RegWrite       = wr.vld;
  assign write_register = wr.addr;
  assign write_data     = wr.dat;
  assign mdu_ready      = !reset && !hold.vld;
  assign starve_stall   = !reset && (starve_cnt >= SC_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      starve_cnt <= '0;
    end else begin
      // Results aimed at r0 are handshaken but never occupy the hold.
      if (drain)
        hold.vld <= 1'b0;
      else if (mdu_valid && !hold.vld && (mdu_reg != REG_ZERO))
        hold <= '{vld: 1'b1, addr: mdu_reg, dat: mdu_data};

      if (drain)
        starve_cnt <= '0;
      else if (hold.vld && (starve_cnt != SC_MAX))
        starve_cnt <= starve_cnt + SC_W'(1);
    end
  end

  regfile_scoreboard #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .issue_vld     (mdu_issue),
    .issue_reg     (mdu_issue_reg),
    .clr_vld       (drain),
    .clr_reg       (hold.addr),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_dest       (id_dest),
    .id_dest_valid (id_dest_valid),
    .hazard_stall  (hazard_stall),
    .mdu_issue_ok  (mdu_issue_ok)
  );
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed scenarios plus randomized traffic checked against a queue/array reference model.
module tb_regfile_wb_arbiter;
  localparam int MAX = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic reset;
  logic pipe_wb_en, mdu_valid, mdu_issue, id_dest_valid;
  logic [4:0] pipe_wb_reg, mdu_reg, mdu_issue_reg, id_rs, id_rt, id_dest;
  logic [31:0] pipe_wb_data, mdu_data;
  logic mdu_ready, mdu_issue_ok, hazard_stall, starve_stall, RegWrite;
  logic [4:0] write_register;
  logic [31:0] write_data;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_busy[32];
  int          m_out;
  logic [36:0] m_hold[$];   // {reg, data}
  int          m_starve;

  // Expected outputs for the current inputs
  logic e_rw, e_ready, e_ok, e_haz, e_starve;
  logic [4:0] e_reg;
  logic [31:0] e_dat;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.MAX_OUTSTANDING(MAX), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .pipe_wb_en(pipe_wb_en), .pipe_wb_reg(pipe_wb_reg), .pipe_wb_data(pipe_wb_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_reg(mdu_reg), .mdu_data(mdu_data),
    .mdu_issue(mdu_issue), .mdu_issue_reg(mdu_issue_reg), .mdu_issue_ok(mdu_issue_ok),
    .id_rs(id_rs), .id_rt(id_rt), .id_dest(id_dest), .id_dest_valid(id_dest_valid),
    .hazard_stall(hazard_stall), .starve_stall(starve_stall),
    .RegWrite(RegWrite), .write_register(write_register), .write_data(write_data)
  );

  task automatic idle();
    reset = 0; pipe_wb_en = 0; pipe_wb_reg = 0; pipe_wb_data = 0;
    mdu_valid = 0; mdu_reg = 0; mdu_data = 0; mdu_issue = 0; mdu_issue_reg = 0;
    id_rs = 0; id_rt = 0; id_dest = 0; id_dest_valid = 0;
  endtask

  task automatic model_outputs();
    bit pipe_on, draining;
    pipe_on  = pipe_wb_en && pipe_wb_reg != 0;
    draining = !pipe_on && m_hold.size() > 0;
    e_rw = 0; e_reg = 0; e_dat = 0;
    if (!reset && pipe_on) begin
      e_rw = 1; e_reg = pipe_wb_reg; e_dat = pipe_wb_data;
    end else if (!reset && draining) begin
      e_rw = 1; e_reg = m_hold[0][36:32]; e_dat = m_hold[0][31:0];
    end
    e_ready  = !reset && m_hold.size() == 0;
    e_starve = !reset && m_starve >= LIMIT;
    e_ok     = !reset && (m_out < MAX || (draining && m_busy[m_hold[0][36:32]]));
    e_haz    = !reset && ((id_rs != 0 && m_busy[id_rs]) || (id_rt != 0 && m_busy[id_rt]) ||
                          (id_dest_valid && id_dest != 0 && m_busy[id_dest]));
  endtask

  // Advance the model by one clock using the rules of the write-port arbiter, then the DUT.
  task automatic tick();
    bit pipe_on, draining, was_empty;
    logic [4:0] dr;
    model_outputs();
    pipe_on   = pipe_wb_en && pipe_wb_reg != 0;
    draining  = !pipe_on && m_hold.size() > 0;
    was_empty = m_hold.size() == 0;
    if (reset) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_out = 0; m_hold.delete(); m_starve = 0;
    end else begin
      if (draining) begin
        dr = m_hold[0][36:32];
        if (m_busy[dr] && m_out > 0) m_out--;
        m_busy[dr] = 0;
        void'(m_hold.pop_front());
        m_starve = 0;
      end else if (!was_empty && m_starve < LIMIT) begin
        m_starve++;
      end
      if (mdu_issue && mdu_issue_reg != 0 && e_ok) begin
        m_busy[mdu_issue_reg] = 1;
        if (m_out < MAX) m_out++;
      end
      if (mdu_valid && was_empty && mdu_reg != 0) m_hold.push_back({mdu_reg, mdu_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1; pipe_wb_en = 1; pipe_wb_reg = 5'd7; pipe_wb_data = 32'hCAFE;
    mdu_valid = 1; mdu_reg = 5'd6; mdu_data = 32'h1; mdu_issue = 1; mdu_issue_reg = 5'd6;
    id_rs = 5'd6; id_rt = 5'd7; id_dest = 5'd6; id_dest_valid = 1;
    #1;
    n_cmp++; if (RegWrite !== 1'b0) begin n_fail++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
    n_cmp++; if (write_register !== 5'd0 || write_data !== 32'd0) begin n_fail++; $display("FAIL reset_port: got %0d/%h want 0/0", write_register, write_data); end
    n_cmp++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mdu_ready: got %b want 0", mdu_ready); end
    n_cmp++; if (hazard_stall !== 1'b0 || starve_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stalls: got %b%b want 00", hazard_stall, starve_stall); end
    n_cmp++; if (mdu_issue_ok !== 1'b0) begin n_fail++; $display("FAIL reset_issue_ok: got %b want 0", mdu_issue_ok); end
    tick();
    idle(); reset = 1;
    tick();
    idle();
    #1;
    n_cmp++; if (mdu_ready !== 1'b1 || mdu_issue_ok !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready_ok: got %b%b want 11", mdu_ready, mdu_issue_ok); end
  endtask

  task automatic test_pipe();
    idle(); pipe_wb_en = 1; pipe_wb_reg = 5'd8; pipe_wb_data = 32'hDEAD;
    #1;
    n_cmp++; if (RegWrite !== 1'b1 || write_register !== 5'd8 || write_data !== 32'hDEAD) begin n_fail++; $display("FAIL pipe_write: got %b r%0d %h want 1 r8 dead", RegWrite, write_register, write_data); end
    tick();
    pipe_wb_reg = 5'd0;
    #1;
    n_cmp++; if (RegWrite !== 1'b0 || write_register !== 5'd0) begin n_fail++; $display("FAIL pipe_r0: got %b r%0d want 0 r0", RegWrite, write_register); end
    tick();
  endtask

  task automatic test_mdu_path();
    idle(); mdu_issue = 1; mdu_issue_reg = 5'd9;
    tick();
    idle(); id_rs = 5'd9;
    #1;
    n_cmp++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL raw_hazard: got %b want 1", hazard_stall); end
    mdu_valid = 1; mdu_reg = 5'd9; mdu_data = 32'h1234;
    #1;
    n_cmp++; if (mdu_ready !== 1'b1 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL mdu_accept: got ready %b rw %b want 1 0", mdu_ready, RegWrite); end
    tick();
    mdu_valid = 0;
    #1;
    n_cmp++; if (RegWrite !== 1'b1 || write_register !== 5'd9 || write_data !== 32'h1234) begin n_fail++; $display("FAIL mdu_write: got %b r%0d %h want 1 r9 1234", RegWrite, write_register, write_data); end
    n_cmp++; if (mdu_ready !== 1'b0) begin n_fail++; $display("FAIL hold_full_ready: got %b want 0", mdu_ready); end
    tick();
    #1;
    n_cmp++; if (hazard_stall !== 1'b0 || mdu_issue_ok !== 1'b1 || RegWrite !== 1'b0) begin n_fail++; $display("FAIL after_drain: got haz %b ok %b rw %b want 0 1 0", hazard_stall, mdu_issue_ok, RegWrite); end
    // WAW via id_dest
    idle(); mdu_issue = 1; mdu_issue_reg = 5'd12;
    tick();
    idle(); id_dest = 5'd12; id_dest_valid = 1;
    #1;
    n_cmp++; if (hazard_stall !== 1'b1) begin n_fail++; $display("FAIL waw_hazard: got %b want 1", hazard_stall); end
    id_dest_valid = 0;
    #1;
    n_cmp++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL dest_invalid: got %b want 0", hazard_stall); end
    mdu_valid = 1; mdu_reg = 5'd12; mdu_data = 32'h77;
    tick();
    idle();
    tick();
  endtask

  task automatic test_starve();
    idle(); mdu_issue = 1; mdu_issue_reg = 5'd9;
    tick();
    idle(); mdu_valid = 1; mdu_reg = 5'd9; mdu_data = 32'h5555;
    tick();
    for (int k = 1; k <= LIMIT; k++) begin
      idle(); pipe_wb_en = 1; pipe_wb_reg = 5'd3; pipe_wb_data = 32'(k);
      #1;
      n_cmp++; if (RegWrite !== 1'b1 || write_register !== 5'd3 || starve_stall !== 1'b0) begin n_fail++; $display("FAIL starve_pipe_%0d: got rw %b r%0d st %b want 1 r3 0", k, RegWrite, write_register, starve_stall); end
      tick();
    end
    #1;
    n_cmp++; if (starve_stall !== 1'b1 || write_register !== 5'd3) begin n_fail++; $display("FAIL starve_on: got st %b r%0d want 1 r3", starve_stall, write_register); end
    idle();
    #1;
    n_cmp++; if (RegWrite !== 1'b1 || write_register !== 5'd9 || write_data !== 32'h5555) begin n_fail++; $display("FAIL starve_drain: got %b r%0d %h want 1 r9 5555", RegWrite, write_register, write_data); end
    tick();
    #1;
    n_cmp++; if (starve_stall !== 1'b0 || mdu_ready !== 1'b1) begin n_fail++; $display("FAIL starve_off: got st %b rdy %b want 0 1", starve_stall, mdu_ready); end
  endtask

  task automatic test_outstanding();
    for (int r = 1; r <= 4; r++) begin
      idle(); mdu_issue = 1; mdu_issue_reg = 5'(r);
      tick();
    end
    idle();
    #1;
    n_cmp++; if (mdu_issue_ok !== 1'b0) begin n_fail++; $display("FAIL issue_full: got %b want 0", mdu_issue_ok); end
    mdu_issue = 1; mdu_issue_reg = 5'd5;
    tick();
    idle(); id_rs = 5'd5;
    #1;
    n_cmp++; if (hazard_stall !== 1'b0) begin n_fail++; $display("FAIL ignored_issue: got %b want 0", hazard_stall); end
    idle(); mdu_valid = 1; mdu_reg = 5'd1; mdu_data = 32'hA1;
    tick();
    idle(); mdu_issue = 1; mdu_issue_reg = 5'd1;
    #1;
    n_cmp++; if (RegWrite !== 1'b1 || write_register !== 5'd1 || mdu_issue_ok !== 1'b1) begin n_fail++; $display("FAIL drain_credit: got rw %b r%0d ok %b want 1 r1 1", RegWrite, write_register, mdu_issue_ok); end
    tick();
    idle(); id_rs = 5'd1;
    #1;
    n_cmp++; if (hazard_stall !== 1'b1 || mdu_issue_ok !== 1'b0) begin n_fail++; $display("FAIL reissue_setwins: got haz %b ok %b want 1 0", hazard_stall, mdu_issue_ok); end
    for (int r = 1; r <= 4; r++) begin
      idle(); mdu_valid = 1; mdu_reg = 5'(r); mdu_data = 32'(r);
      tick();
      idle();
      tick();
    end
    id_rs = 5'd1; id_rt = 5'd4;
    #1;
    n_cmp++; if (hazard_stall !== 1'b0 || mdu_issue_ok !== 1'b1) begin n_fail++; $display("FAIL all_drained: got haz %b ok %b want 0 1", hazard_stall, mdu_issue_ok); end
  endtask

  task automatic test_reset_mid();
    idle(); mdu_issue = 1; mdu_issue_reg = 5'd5;
    tick();
    idle(); mdu_valid = 1; mdu_reg = 5'd5; mdu_data = 32'hBEEF;
    tick();
    idle(); reset = 1;
    tick();
    idle(); id_rs = 5'd5;
    #1;
    n_cmp++; if (RegWrite !== 1'b0 || hazard_stall !== 1'b0 || mdu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid: got rw %b haz %b rdy %b want 0 0 1", RegWrite, hazard_stall, mdu_ready); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      pipe_wb_en    = (i < 400) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 2) == 0);
      pipe_wb_reg   = 5'($urandom_range(0, 7));
      pipe_wb_data  = $urandom;
      mdu_valid     = 1'($urandom_range(0, 1));
      mdu_reg       = 5'($urandom_range(0, 7));
      mdu_data      = $urandom;
      mdu_issue     = ($urandom_range(0, 2) == 0);
      mdu_issue_reg = 5'($urandom_range(0, 7));
      id_rs         = 5'($urandom_range(0, 7));
      id_rt         = 5'($urandom_range(0, 7));
      id_dest       = 5'($urandom_range(0, 7));
      id_dest_valid = 1'($urandom_range(0, 1));
      #1;
      model_outputs();
      n_cmp++; if (RegWrite !== e_rw || write_register !== e_reg || write_data !== e_dat) begin n_fail++; $display("FAIL rnd_port@%0d: got %b r%0d %h want %b r%0d %h", i, RegWrite, write_register, write_data, e_rw, e_reg, e_dat); end
      n_cmp++; if (mdu_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready@%0d: got %b want %b", i, mdu_ready, e_ready); end
      n_cmp++; if (mdu_issue_ok !== e_ok) begin n_fail++; $display("FAIL rnd_issue_ok@%0d: got %b want %b", i, mdu_issue_ok, e_ok); end
      n_cmp++; if (hazard_stall !== e_haz) begin n_fail++; $display("FAIL rnd_hazard@%0d: got %b want %b", i, hazard_stall, e_haz); end
      n_cmp++; if (starve_stall !== e_starve) begin n_fail++; $display("FAIL rnd_starve@%0d: got %b want %b", i, starve_stall, e_starve); end
      tick();
    end
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 0;
    m_out = 0; m_starve = 0;
    idle();
    test_reset();
    test_pipe();
    test_mdu_path();
    test_starve();
    test_outstanding();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
